arcade_input_map: RTL and testbench
===================================

Name: arcade_input_map

Overview:
- Parametrised player-control front end for arcade cores: merges PS/2 keyboard events and HPS joysticks into per-player active-low button vectors.
- Adds features the single-player fixed mapping lacked: N players, M fire buttons, per-player coin-pulse sequencer, autofire, and 90°/180° remap.
- Sits between hps_io outputs and the game core's button inputs, all on clk_sys.

Parameters:
- PLAYERS, 2, number of player channels (1..4)
- BUTTONS, 4, fire buttons per player (1..4); joystick bits [4+:BUTTONS]
- COIN_TICKS, 4, coin pulse length and holdoff, in tick periods (1..255)
- AF_TICKS, 3, autofire half-period in tick periods (1..255)
- COIN_ON_START, 1, start press also launches a coin pulse on the same channel

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- tick  in  1  timing enable for coin/autofire counters (typically 1 per frame)
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8:0] extended scan code
- joystick  in  16*PLAYERS  per-player joystick words; bits 0..3 = R,L,D,U, 4+ = fire
- orient_horz  in  1  1 = 90° remap of directions
- flip  in  1  1 = 180° remap, applied after orient_horz
- autofire_en  in  PLAYERS  per-player autofire on fire button 0
- ctrl_n  out  (4+BUTTONS)*PLAYERS  active-low {fire[BUTTONS-1:0],R,L,D,U} per player
- start_n  out  PLAYERS  active-low start
- coin_n  out  PLAYERS  active-low coin pulse

Behaviour:
- Reset: all key state, edge registers and counters cleared; all outputs 1 (inactive); coin FSMs in IDLE.
- PS/2: sample ps2_key[10] into old bit; on mismatch, decode code and set key reg <= pressed. Unlisted codes are ignored.
- Keys, player 0 only: E075 U, E072 D, E06B L, E074 R, 014/029/011/012 fire0..3. Starts F1, F2, F3, F4 (005, 006, 004, 00C) for players 0..3. Coins '5','6','7','8' (02E, 036, 03D, 03E). Codes for channels ≥ PLAYERS or buttons ≥ BUTTONS are ignored.
- Raw per player: key OR joystick bit.
- orient_horz=1 remap: U<=L, D<=R, L<=D, R<=U.
- flip=1 remap: swap U<->D and L<->R.
- Latency:
  - Joystick change → ctrl_n: 1 clk.
  - PS/2 event sampled at edge k → key reg at k → ctrl_n at k+1.
- Autofire, per player, with autofire_en=1:
  - On fire0 rising, output asserts immediately (next clk) and AF counter loads AF_TICKS.
  - While held, each tick decrements; at 0, output toggles and counter reloads.
  - On release, output deasserts next clk and counter clears.
  - With autofire_en=0, fire0 passes through.
- Coin FSM, per player: IDLE → ACTIVE → HOLDOFF → IDLE.
  - Trigger: coin rising edge, or start rising edge when COIN_ON_START=1.
  - IDLE + trigger → ACTIVE: coin_n=0, counter=COIN_TICKS.
  - ACTIVE: decrement per tick; at 0 → HOLDOFF, coin_n=1, counter=COIN_TICKS.
  - HOLDOFF: decrement per tick; at 0 → IDLE.
  - Triggers in ACTIVE or HOLDOFF are dropped (no queue).
  - Trigger coincident with the IDLE-entry cycle is honoured next clk.
  - Coin_n lasts COIN_TICKS ticks ±1 tick phase.
- start_n: level of raw start, 1 clk registered.
- Simultaneous keyboard and joystick on the same bit: OR. Opposing directions are passed unchanged.
- reset_n asserted mid-pulse: coin_n returns to 1 immediately (async); no pulse resumes after release.
- tick held high continuously is legal: counters then run at clk rate.

Decomposition:
- Package arcade_input_pkg: scan-code localparams, direction bit indices, coin FSM state enum.
- One sub-module: arcade_coin_seq (single-channel coin FSM + counter), instantiated PLAYERS times via generate.

Test Plan:
- Reset: reset_n=0 with all inputs active → every output 1; release → outputs follow inputs after 1 clk.
- PS/2: toggle ps2_key[10] with {1,E075} → ctrl_n[U] of p0 = 0 two clk later. Toggle with {0,E075} → 1. Repeat with no toggle → no change.
- Remap: joystick p0 U=1, orient_horz=1 → R asserted. Add flip=1 → L asserted.
- Coin: COIN_TICKS=4, press F1 → coin_n[0]=0 for 4 ticks, then 4-tick holdoff. Re-press inside holdoff → no pulse; press after → pulse.
- Autofire: AF_TICKS=3, autofire_en[1]=1, hold p1 fire0 for 20 ticks → fire0 alternates every 3 ticks starting low. Release → high next clk.
- Channel limits: PLAYERS=1 → F2 and '6' events produce no output change; reset mid-ACTIVE → coin_n=1 and FSM in IDLE after release.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade control front end: scan codes, direction
// layout, coin sequencer states and the PS/2 key decoder.
package arcade_input_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned JOY_W = 16;
  localparam int unsigned DIR_W = 4;

  localparam int unsigned JOY_R = 0;
  localparam int unsigned JOY_L = 1;
  localparam int unsigned JOY_D = 2;
  localparam int unsigned JOY_U = 3;

  localparam logic [8:0] SC_UP     = 9'h175;
  localparam logic [8:0] SC_DOWN   = 9'h172;
  localparam logic [8:0] SC_LEFT   = 9'h16B;
  localparam logic [8:0] SC_RIGHT  = 9'h174;
  localparam logic [8:0] SC_FIRE0  = 9'h014;
  localparam logic [8:0] SC_FIRE1  = 9'h029;
  localparam logic [8:0] SC_FIRE2  = 9'h011;
  localparam logic [8:0] SC_FIRE3  = 9'h012;
  localparam logic [8:0] SC_START0 = 9'h005;
  localparam logic [8:0] SC_START1 = 9'h006;
  localparam logic [8:0] SC_START2 = 9'h004;
  localparam logic [8:0] SC_START3 = 9'h00C;
  localparam logic [8:0] SC_COIN0  = 9'h02E;
  localparam logic [8:0] SC_COIN1  = 9'h036;
  localparam logic [8:0] SC_COIN2  = 9'h03D;
  localparam logic [8:0] SC_COIN3  = 9'h03E;

  // Output order {R,L,D,U}: u is bit 0
  typedef struct packed {
    logic r;
    logic l;
    logic d;
    logic u;
  } dirs_t;

  typedef enum logic [1:0] {
    CS_IDLE    = 2'd0,
    CS_ACTIVE  = 2'd1,
    CS_HOLDOFF = 2'd2
  } coin_state_e;

  typedef enum logic [2:0] {
    KK_NONE  = 3'd0,
    KK_DIR   = 3'd1,
    KK_FIRE  = 3'd2,
    KK_START = 3'd3,
    KK_COIN  = 3'd4
  } key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [1:0] idx;
  } key_dec_t;

  // Direction idx follows dirs_t bit positions (U=0, D=1, L=2, R=3)
  function automatic key_dec_t decode_key(input logic [8:0] code);
    key_dec_t k;
    k.kind = KK_NONE;
    k.idx  = 2'd0;
    case (code)
      SC_UP:     begin k.kind = KK_DIR;   k.idx = 2'd0; end
      SC_DOWN:   begin k.kind = KK_DIR;   k.idx = 2'd1; end
      SC_LEFT:   begin k.kind = KK_DIR;   k.idx = 2'd2; end
      SC_RIGHT:  begin k.kind = KK_DIR;   k.idx = 2'd3; end
      SC_FIRE0:  begin k.kind = KK_FIRE;  k.idx = 2'd0; end
      SC_FIRE1:  begin k.kind = KK_FIRE;  k.idx = 2'd1; end
      SC_FIRE2:  begin k.kind = KK_FIRE;  k.idx = 2'd2; end
      SC_FIRE3:  begin k.kind = KK_FIRE;  k.idx = 2'd3; end
      SC_START0: begin k.kind = KK_START; k.idx = 2'd0; end
      SC_START1: begin k.kind = KK_START; k.idx = 2'd1; end
      SC_START2: begin k.kind = KK_START; k.idx = 2'd2; end
      SC_START3: begin k.kind = KK_START; k.idx = 2'd3; end
      SC_COIN0:  begin k.kind = KK_COIN;  k.idx = 2'd0; end
      SC_COIN1:  begin k.kind = KK_COIN;  k.idx = 2'd1; end
      SC_COIN2:  begin k.kind = KK_COIN;  k.idx = 2'd2; end
      SC_COIN3:  begin k.kind = KK_COIN;  k.idx = 2'd3; end
      default:   ;
    endcase
    return k;
  endfunction

  // 90 degree rotation first, then 180 degree flip
  function automatic dirs_t remap(input dirs_t d, input logic orient, input logic flp);
    dirs_t o;
    dirs_t f;
    o = d;
    if (orient) begin
      o.u = d.l;
      o.d = d.r;
      o.l = d.d;
      o.r = d.u;
    end
    f = o;
    if (flp) begin
      f.u = o.d;
      f.d = o.u;
      f.l = o.r;
      f.r = o.l;
    end
    return f;
  endfunction

endpackage

// File: rtl/arcade_coin_seq.sv
// Single-channel coin pulse sequencer: fixed-length active-low pulse followed
// by an equal holdoff during which new triggers are dropped.
module arcade_coin_seq
  import arcade_input_pkg::*;
#(
  parameter int unsigned COIN_TICKS    = 4,
  parameter bit          COIN_ON_START = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic coin_i,
  input  logic start_i,
  output logic coin_n_o
);

  coin_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coin_prev_q, start_prev_q;
  logic             pend_q, pend_d;
  logic             coin_n_q, coin_n_d;
  logic             trig;

  assign trig = (coin_i & ~coin_prev_q) | (COIN_ON_START & start_i & ~start_prev_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    case (state_q)
      CS_IDLE: begin
        if (trig || pend_q) begin
          state_d = CS_ACTIVE;
          cnt_d   = CNT_W'(COIN_TICKS);
        end
      end
      CS_ACTIVE: begin
        if (tick_i) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = CS_HOLDOFF;
            cnt_d   = CNT_W'(COIN_TICKS);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      CS_HOLDOFF: begin
        if (tick_i) begin
          if (cnt_q <= CNT_W'(1)) begin
            // A trigger landing on the IDLE-entry edge is carried one clock
            state_d = CS_IDLE;
            cnt_d   = '0;
            pend_d  = trig;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = CS_IDLE;
        cnt_d   = '0;
      end
    endcase
    coin_n_d = (state_d != CS_ACTIVE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CS_IDLE;
      cnt_q        <= '0;
      coin_prev_q  <= 1'b0;
      start_prev_q <= 1'b0;
      pend_q       <= 1'b0;
      coin_n_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      coin_prev_q  <= coin_i;
      start_prev_q <= start_i;
      pend_q       <= pend_d;
      coin_n_q     <= coin_n_d;
    end
  end

  assign coin_n_o = coin_n_q;

endmodule

// File: rtl/arcade_input_map.sv
// Player-control front end: merges PS/2 keys and joysticks into per-player
// active-low buttons with remap, autofire and coin pulse sequencing.
module arcade_input_map
  import arcade_input_pkg::*;
#(
  parameter int unsigned PLAYERS       = 2,
  parameter int unsigned BUTTONS       = 4,
  parameter int unsigned COIN_TICKS    = 4,
  parameter int unsigned AF_TICKS      = 3,
  parameter bit          COIN_ON_START = 1'b1
) (
  input  logic                                clk_sys,
  input  logic                                reset_n,
  input  logic                                tick,
  input  logic [10:0]                         ps2_key,
  input  logic [JOY_W*PLAYERS-1:0]            joystick,
  input  logic                                orient_horz,
  input  logic                                flip,
  input  logic [PLAYERS-1:0]                  autofire_en,
  output logic [(DIR_W+BUTTONS)*PLAYERS-1:0]  ctrl_n,
  output logic [PLAYERS-1:0]                  start_n,
  output logic [PLAYERS-1:0]                  coin_n
);

  localparam int unsigned CW = DIR_W + BUTTONS;

  logic                         ps2_old_q;
  logic [DIR_W-1:0]             key_dir_q, key_dir_d;
  logic [BUTTONS-1:0]           key_fire_q, key_fire_d;
  logic [PLAYERS-1:0]           key_start_q, key_start_d;
  logic [PLAYERS-1:0]           key_coin_q, key_coin_d;
  logic [CW*PLAYERS-1:0]        ctrl_n_q, ctrl_n_d;
  logic [PLAYERS-1:0]           start_n_q, start_n_d;
  logic [PLAYERS-1:0]           af_prev_q, af_prev_d;
  logic [PLAYERS-1:0]           af_out_q, af_out_d;
  logic [PLAYERS-1:0][CNT_W-1:0] af_cnt_q, af_cnt_d;
  key_dec_t                     ps2_dec;
  logic [PLAYERS-1:0]           unused_joy;

  assign ps2_dec = decode_key(ps2_key[8:0]);

  // Keyboard state: a toggle of bit 10 marks a new make/break event
  always_comb begin
    key_dir_d   = key_dir_q;
    key_fire_d  = key_fire_q;
    key_start_d = key_start_q;
    key_coin_d  = key_coin_q;
    if (ps2_key[10] != ps2_old_q) begin
      case (ps2_dec.kind)
        KK_DIR: key_dir_d[ps2_dec.idx] = ps2_key[9];
        KK_FIRE: begin
          for (int b = 0; b < int'(BUTTONS); b++)
            if (ps2_dec.idx == 2'(b)) key_fire_d[b] = ps2_key[9];
        end
        KK_START: begin
          for (int p = 0; p < int'(PLAYERS); p++)
            if (ps2_dec.idx == 2'(p)) key_start_d[p] = ps2_key[9];
        end
        KK_COIN: begin
          for (int p = 0; p < int'(PLAYERS); p++)
            if (ps2_dec.idx == 2'(p)) key_coin_d[p] = ps2_key[9];
        end
        default: ;
      endcase
    end
  end

  // Per-player merge, remap and autofire on fire0
  always_comb begin
    logic [DIR_W-1:0]   raw_v;
    dirs_t              dir_v;
    logic [BUTTONS-1:0] fire_v;
    raw_v     = '0;
    dir_v     = '0;
    fire_v    = '0;
    ctrl_n_d  = '1;
    start_n_d = '1;
    af_prev_d = af_prev_q;
    af_out_d  = af_out_q;
    af_cnt_d  = af_cnt_q;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      raw_v = {joystick[p*JOY_W + JOY_R], joystick[p*JOY_W + JOY_L],
               joystick[p*JOY_W + JOY_D], joystick[p*JOY_W + JOY_U]}
              | ((p == 0) ? key_dir_q : '0);
      dir_v  = remap(dirs_t'(raw_v), orient_horz, flip);
      fire_v = joystick[p*JOY_W + DIR_W +: BUTTONS] | ((p == 0) ? key_fire_q : '0);

      af_prev_d[p] = fire_v[0];
      if (!fire_v[0]) begin
        af_out_d[p] = 1'b0;
        af_cnt_d[p] = '0;
      end else if (!af_prev_q[p]) begin
        af_out_d[p] = 1'b1;
        af_cnt_d[p] = CNT_W'(AF_TICKS);
      end else if (tick) begin
        if (af_cnt_q[p] <= CNT_W'(1)) begin
          af_out_d[p] = ~af_out_q[p];
          af_cnt_d[p] = CNT_W'(AF_TICKS);
        end else begin
          af_cnt_d[p] = af_cnt_q[p] - CNT_W'(1);
        end
      end
      if (autofire_en[p]) fire_v[0] = af_out_d[p];

      ctrl_n_d[p*CW +: CW] = ~{fire_v, dir_v};
      start_n_d[p]         = ~key_start_q[p];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_old_q   <= 1'b0;
      key_dir_q   <= '0;
      key_fire_q  <= '0;
      key_start_q <= '0;
      key_coin_q  <= '0;
      ctrl_n_q    <= '1;
      start_n_q   <= '1;
      af_prev_q   <= '0;
      af_out_q    <= '0;
      af_cnt_q    <= '0;
    end else begin
      ps2_old_q   <= ps2_key[10];
      key_dir_q   <= key_dir_d;
      key_fire_q  <= key_fire_d;
      key_start_q <= key_start_d;
      key_coin_q  <= key_coin_d;
      ctrl_n_q    <= ctrl_n_d;
      start_n_q   <= start_n_d;
      af_prev_q   <= af_prev_d;
      af_out_q    <= af_out_d;
      af_cnt_q    <= af_cnt_d;
    end
  end

  assign ctrl_n  = ctrl_n_q;
  assign start_n = start_n_q;

  for (genvar g = 0; g < int'(PLAYERS); g++) begin : g_player
    arcade_coin_seq #(
      .COIN_TICKS    (COIN_TICKS),
      .COIN_ON_START (COIN_ON_START)
    ) u_coin (
      .clk_i    (clk_sys),
      .rst_ni   (reset_n),
      .tick_i   (tick),
      .coin_i   (key_coin_q[g]),
      .start_i  (key_start_q[g]),
      .coin_n_o (coin_n[g])
    );
    // Joystick bits above the fire buttons carry nothing for this block
    assign unused_joy[g] = ^joystick[g*JOY_W + CW +: JOY_W - CW];
  end

endmodule

// File: tb/tb_arcade_input_map.sv
// Directed-vector bench with a cycle-stamped scoreboard for arcade_input_map
// (two players) and a single-player instance for channel limits.
module tb_arcade_input_map;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [10:0] ps2_key, ps2_key1;
  logic [31:0] joystick;
  logic [15:0] joystick1;
  logic        orient_horz, flip;
  logic [1:0]  autofire_en;
  logic [0:0]  autofire_en1;
  logic [15:0] ctrl_n;
  logic [1:0]  start_n, coin_n;
  logic [7:0]  ctrl_n1;
  logic [0:0]  start_n1, coin_n1;

  always #5 clk_sys = ~clk_sys;

  arcade_input_map #(.PLAYERS(2), .BUTTONS(4), .COIN_TICKS(4), .AF_TICKS(3), .COIN_ON_START(1'b1)) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick), .ps2_key(ps2_key), .joystick(joystick),
    .orient_horz(orient_horz), .flip(flip), .autofire_en(autofire_en),
    .ctrl_n(ctrl_n), .start_n(start_n), .coin_n(coin_n));

  arcade_input_map #(.PLAYERS(1), .BUTTONS(4), .COIN_TICKS(4), .AF_TICKS(3), .COIN_ON_START(1'b1)) u_dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick), .ps2_key(ps2_key1), .joystick(joystick1),
    .orient_horz(orient_horz), .flip(flip), .autofire_en(autofire_en1),
    .ctrl_n(ctrl_n1), .start_n(start_n1), .coin_n(coin_n1));

  // Observation vector: [19:18] coin_n, [17:16] start_n, [15:0] ctrl_n
  localparam int P0_U = 0, P0_D = 1, P0_L = 2, P0_R = 3, P0_F0 = 4;
  localparam int P1_F0 = 12, P1_F1 = 13, ST0 = 16, CN0 = 18;

  typedef struct {
    int unsigned cyc;
    bit          sel;
    logic [19:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [19:0] mon_obs;
  logic [19:0] m0, m1;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Monitor: compare every entry whose due cycle has arrived
  always @(negedge clk_sys) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_obs = mon_e.sel ? {1'b1, coin_n1, 1'b1, start_n1, 8'hFF, ctrl_n1}
                          : {coin_n, start_n, ctrl_n};
      checks++;
      if (mon_obs !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h at cycle %0d", mon_e.name, mon_obs, mon_e.exp, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic push(input int unsigned lat, input bit sel, input string nm);
    exp_t e;
    int   i;
    e.cyc  = cyc + lat;
    e.sel  = sel;
    e.exp  = sel ? m1 : m0;
    e.name = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > e.cyc) i--;
    sb.insert(i, e);
  endtask

  task automatic ps2_ev(input bit d1, input bit pressed, input logic [8:0] code);
    logic t;
    if (!d1) begin
      t = ~ps2_key[10];
      ps2_key = {t, pressed, code};
    end else begin
      t = ~ps2_key1[10];
      ps2_key1 = {t, pressed, code};
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; ps2_key = '0; ps2_key1 = '0;
    joystick = '1; joystick1 = '1; orient_horz = 1'b0; flip = 1'b0;
    autofire_en = '0; autofire_en1 = '0;
    m0 = '1; m1 = '1;

    // Reset with inputs active, then release
    step(1);
    push(0, 0, "reset_p2"); push(0, 1, "reset_p1");
    step(1);
    push(0, 0, "reset_p2_hold");
    reset_n = 1'b1;
    m0 = 20'hF0000; m1 = 20'hFFF00;
    push(1, 0, "rst_release_joy"); push(1, 1, "rst_release_joy_p1");
    step(1);
    joystick = '0; joystick1 = '0;
    m0 = '1; m1 = '1;
    push(1, 0, "joy_release"); push(1, 1, "joy_release_p1");
    step(2);

    // PS/2 up key: two-clock latency, release, no-toggle, unlisted code
    ps2_ev(0, 1'b1, 9'h175);
    push(1, 0, "ps2_up_lat1");
    m0[P0_U] = 1'b0;
    push(2, 0, "ps2_up_lat2");
    step(4);
    push(0, 0, "ps2_up_hold");
    ps2_ev(0, 1'b0, 9'h175);
    m0[P0_U] = 1'b1;
    push(2, 0, "ps2_up_release");
    step(3);
    ps2_key[9] = 1'b1;
    push(2, 0, "ps2_no_toggle");
    step(3);
    ps2_ev(0, 1'b1, 9'h01C);
    push(2, 0, "ps2_unlisted");
    step(3);
    ps2_ev(0, 1'b1, 9'h014);
    m0[P0_F0] = 1'b0;
    push(2, 0, "ps2_fire0");
    step(3);
    joystick[4] = 1'b1;
    ps2_ev(0, 1'b0, 9'h014);
    push(2, 0, "or_key_joy");
    step(3);
    joystick[4] = 1'b0;
    m0[P0_F0] = 1'b1;
    push(1, 0, "fire0_clear");
    step(2);

    // Remap of joystick up on player 0
    joystick[3] = 1'b1; orient_horz = 1'b1;
    m0[P0_R] = 1'b0;
    push(1, 0, "orient_u_to_r");
    step(2);
    flip = 1'b1;
    m0[P0_R] = 1'b1; m0[P0_L] = 1'b0;
    push(1, 0, "orient_flip_l");
    step(2);
    orient_horz = 1'b0;
    m0[P0_L] = 1'b1; m0[P0_D] = 1'b0;
    push(1, 0, "flip_u_to_d");
    step(2);
    flip = 1'b0; joystick = '0;
    m0[P0_D] = 1'b1;
    push(1, 0, "remap_clear");
    step(2);
    joystick[0] = 1'b1; joystick[1] = 1'b1; joystick[21] = 1'b1;
    m0[P0_R] = 1'b0; m0[P0_L] = 1'b0; m0[P1_F1] = 1'b0;
    push(1, 0, "opposing_rl_p1_fire1");
    step(2);
    joystick = '0;
    m0 = '1;
    push(1, 0, "joy_clear");
    step(2);

    // Autofire on player 1 with tick held high: 3 low, 3 high, ...
    autofire_en = 2'b10; tick = 1'b1; joystick[20] = 1'b1;
    for (int l = 1; l <= 13; l++) begin
      m0[P1_F0] = (((l - 1) / 3) % 2 == 0) ? 1'b0 : 1'b1;
      push(l, 0, "af_p1");
    end
    step(13);
    joystick[20] = 1'b0; tick = 1'b0;
    m0[P1_F0] = 1'b1;
    push(1, 0, "af_release");
    step(2);
    autofire_en = '0;

    // Coin via F1 start: 4-tick pulse, 4-tick holdoff drops re-press
    ps2_ev(0, 1'b1, 9'h005);
    m0[ST0] = 1'b0; m0[CN0] = 1'b0;
    push(2, 0, "f1_start_coin");
    step(3);
    ps2_ev(0, 1'b0, 9'h005);
    m0[ST0] = 1'b1;
    push(2, 0, "f1_release");
    step(3);
    repeat (3) pulse_tick();
    push(0, 0, "coin_after_3ticks");
    pulse_tick();
    m0[CN0] = 1'b1;
    push(0, 0, "coin_end_4ticks");
    pulse_tick();
    ps2_ev(0, 1'b1, 9'h005);
    m0[ST0] = 1'b0;
    push(2, 0, "holdoff_press_dropped");
    step(3);
    ps2_ev(0, 1'b0, 9'h005);
    m0[ST0] = 1'b1;
    push(2, 0, "holdoff_release");
    step(3);
    repeat (3) pulse_tick();
    push(0, 0, "idle_after_holdoff");
    ps2_ev(0, 1'b1, 9'h005);
    m0[ST0] = 1'b0; m0[CN0] = 1'b0;
    push(2, 0, "coin_after_holdoff");
    step(3);
    ps2_ev(0, 1'b0, 9'h005);
    m0[ST0] = 1'b1;
    push(2, 0, "f1_release2");
    step(3);

    // Single-player instance ignores channel-1 start and coin
    ps2_ev(1, 1'b1, 9'h006);
    push(2, 1, "p1only_f2_ignored");
    step(3);
    ps2_ev(1, 1'b1, 9'h036);
    push(2, 1, "p1only_coin6_ignored");
    step(3);
    ps2_ev(1, 1'b1, 9'h005);
    m1[ST0] = 1'b0; m1[CN0] = 1'b0;
    push(2, 1, "p1only_f1");
    step(3);

    // Asynchronous reset mid-pulse, no pulse afterwards
    reset_n = 1'b0; ps2_key = '0; ps2_key1 = '0;
    m0 = '1; m1 = '1;
    push(0, 0, "rst_mid_active_p2"); push(0, 1, "rst_mid_active_p1");
    step(2);
    reset_n = 1'b1;
    push(1, 0, "rst_release_p2"); push(1, 1, "rst_release_p1");
    step(2);
    pulse_tick();
    push(4, 0, "no_resume_p2"); push(4, 1, "no_resume_p1");
    step(5);

    for (int w = 0; w < 20 && sb.size() != 0; w++) step(1);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
